peripheral_native_registers: RTL
================================

PERIPHERAL_NATIVE_REGISTERS -- requirements
Module: peripheral_native_registers

Interface
REQ-001 Parameter FIFO_DEPTH, 16, number of 8-bit FIFO entries; legal range 2..255, power of two.
REQ-002 Parameter LT_THRESHOLD, 1000, compare constant for lt_1k_out.
REQ-003 Ports are carried on peripheral_native_register_interface; this block uses the modport opposite to the register map.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 count_we  in  1  load counter from count_in this cycle.
REQ-007 count_in  in  32  counter load value.
REQ-008 count_out  out  32  current counter value.
REQ-009 config_we  in  1  load en/dir/ire from en_in/dir_in/ire_in.
REQ-010 en_in, dir_in, ire_in  in  1 each  count enable; direction (1 = up); wrap-interrupt enable.
REQ-011 en_out, dir_out, ire_out  out  1 each  registered config bits.
REQ-012 lt_1k_out  out  1  count_out < LT_THRESHOLD.
REQ-013 fifo_we  in  1  push fifo_data_in.
REQ-014 fifo_data_in  in  8  push data.
REQ-015 fifo_re  in  1  pop head entry.
REQ-016 fifo_data_out  out  8  head entry, first-word fall-through.
REQ-017 fifo_empty, fifo_full  out  1 each  occupancy flags.
REQ-018 fifo_word_count  out  8  number of stored entries, 0..FIFO_DEPTH.
REQ-019 count_irq  out  1  one-cycle wrap-interrupt pulse.

Function
REQ-020 Counter: count_we=1 loads count_in, which has priority over counting; otherwise if en_out=1, counter +1 when dir_out=1 and -1 when dir_out=0, modulo 2^32.
REQ-021 Wrap: count_irq asserts for exactly one cycle, one cycle after the edge on which a count step wraps (FFFFFFFF->0 up, 0->FFFFFFFF down), only if ire_out=1 at that edge; a load never raises count_irq.
REQ-022 Config: config_we=1 updates en/dir/ire at the next edge; the new values take effect from the following cycle (counting in the same cycle uses the old values).
REQ-023 lt_1k_out is combinational from the registered count_out; 999 -> 1, 1000 -> 0.
REQ-024 FIFO push: fifo_we with fifo_full=0 writes an entry; fifo_we with fifo_full=1 is dropped and state is unchanged.
REQ-025 FIFO pop: fifo_re with fifo_empty=0 removes the head; fifo_re with fifo_empty=1 is ignored.
REQ-026 Simultaneous push+pop when not empty and not full: both occur and the count is unchanged.
REQ-027 Simultaneous push+pop when full: both occur and the count stays FIFO_DEPTH.
REQ-028 Simultaneous push+pop when empty: only the push occurs and the count becomes 1.
REQ-029 fifo_data_out is the head entry combinationally, 8'h00 when empty; a pushed word is visible the cycle after the push edge.
REQ-030 Read/write pointers wrap modulo FIFO_DEPTH.
REQ-031 fifo_empty = (count == 0); fifo_full = (count == FIFO_DEPTH); both are derived from the registered count.

Reset
REQ-032 reset=1 at an edge: count_out=0, en_out=0, dir_out=1, ire_out=0, count_irq=0, FIFO pointers and count=0 (fifo_empty=1, fifo_full=0, fifo_data_out=8'h00).
REQ-033 reset has priority over all writes, pushes and pops in the same cycle; FIFO memory contents are not reset.
REQ-034 Reset asserted mid-operation discards all FIFO contents and any pending count_irq.

Structure
REQ-035 Package peripheral_pkg holds COUNT_WIDTH=32, FIFO_DATA_WIDTH=8, FIFO_COUNT_WIDTH=8, default FIFO_DEPTH and LT_THRESHOLD.
REQ-036 The FIFO is a sub-module, peripheral_sync_fifo (FWFT, parameterised depth and width); counter and config logic live in the top module.

Verification
REQ-037 Load 32'hFFFF_FFFE, set en=1, dir=1, ire=1 -> count goes FFFFFFFF then 0; count_irq=1 for one cycle only, one cycle after the wrap edge.
REQ-038 Load 1001, en=1, dir=0 -> lt_1k_out goes 0,0,1 as count goes 1001,1000,999; no irq.
REQ-039 Push 16 bytes 0x01..0x10 -> fifo_full=1, count=16; a 17th push with 0xFF is dropped; 16 pops return 0x01..0x10, then fifo_empty=1 and fifo_data_out=0x00.
REQ-040 With FIFO full, push 0xAA and pop in the same cycle -> count stays 16, head advances, and 0xAA is the last word read out; on an empty FIFO, simultaneous push 0x55 + pop -> count=1, head=0x55.
REQ-041 count_we and en=1 in the same cycle -> count equals count_in with no increment; a pop on an empty FIFO -> no change.
REQ-042 Reset with FIFO holding 5 entries and count=1234 -> every output at its REQ-032 value on the next cycle.

Source files
------------

// File: rtl/peripheral_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_pkg
// Purpose  : Shared widths and default parameter values for the native
//            register peripheral (counter, config bits, byte FIFO).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package peripheral_pkg;

  localparam int COUNT_WIDTH          = 32;
  localparam int FIFO_DATA_WIDTH      = 8;
  localparam int FIFO_COUNT_WIDTH     = 8;
  localparam int DEFAULT_FIFO_DEPTH   = 16;
  localparam int DEFAULT_LT_THRESHOLD = 1000;

endpackage : peripheral_pkg
`default_nettype wire

// File: rtl/peripheral_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO. The head entry is
//            presented combinationally on data_out (zero when empty).
// Ports    : clk, reset         - clock, synchronous active-high reset
//            we, data_in        - push request and data
//            re                 - pop request
//            data_out           - head entry (FWFT), 0 when empty
//            empty, full        - occupancy flags from the registered count
//            word_count         - number of stored entries, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_sync_fifo
  import peripheral_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_FIFO_DEPTH,
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int COUNT_WIDTH = FIFO_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   re,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   empty,
  output logic                   full,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [COUNT_WIDTH-1:0] C_DEPTH     = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] C_CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [AW-1:0]          C_PTR_ONE   = AW'(1);

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q,  count_d;

  logic push_ok;
  logic pop_ok;

  assign empty      = (count_q == '0);
  assign full       = (count_q == C_DEPTH);
  assign word_count = count_q;
  assign data_out   = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees the head slot
  // in the same cycle; a pop on an empty FIFO is ignored, so a push+pop on
  // empty degenerates to a plain push.
  assign pop_ok  = re && !empty;
  assign push_ok = we && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so natural pointer overflow is the wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= data_in;
  end

endmodule : peripheral_sync_fifo
`default_nettype wire

// File: rtl/peripheral_native_registers.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_native_registers
// Purpose  : Native register peripheral: loadable up/down 32-bit counter with
//            wrap interrupt, three config bits, threshold compare, and a
//            byte-wide FWFT FIFO. Port list is the peripheral side of the
//            register-map bus.
// Ports    : clk, reset                      - clock, sync active-high reset
//            count_we, count_in, count_out   - counter load / value
//            config_we, en/dir/ire_in        - config write
//            en/dir/ire_out                  - registered config bits
//            lt_1k_out                       - count_out < LT_THRESHOLD
//            fifo_we/re, fifo_data_in/out    - FIFO push / pop / data
//            fifo_empty/full/word_count      - FIFO occupancy
//            count_irq                       - one-cycle wrap pulse
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_native_registers
  import peripheral_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int LT_THRESHOLD = DEFAULT_LT_THRESHOLD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        count_we,
  input  logic [COUNT_WIDTH-1:0]      count_in,
  output logic [COUNT_WIDTH-1:0]      count_out,
  input  logic                        config_we,
  input  logic                        en_in,
  input  logic                        dir_in,
  input  logic                        ire_in,
  output logic                        en_out,
  output logic                        dir_out,
  output logic                        ire_out,
  output logic                        lt_1k_out,
  input  logic                        fifo_we,
  input  logic [FIFO_DATA_WIDTH-1:0]  fifo_data_in,
  input  logic                        fifo_re,
  output logic [FIFO_DATA_WIDTH-1:0]  fifo_data_out,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [FIFO_COUNT_WIDTH-1:0] fifo_word_count,
  output logic                        count_irq
);

  localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] C_LT  = COUNT_WIDTH'(LT_THRESHOLD);

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   en_q,  en_d;
  logic                   dir_q, dir_d;
  logic                   ire_q, ire_d;
  logic                   irq_q, irq_d;
  logic                   step;
  logic                   wrap;

  // A load suppresses the step, so it can never produce a wrap interrupt.
  assign step = en_q && !count_we;
  assign wrap = step && (dir_q ? (count_q == '1) : (count_q == '0));

  always_comb begin
    count_d = count_q;
    if (count_we) begin
      count_d = count_in;
    end else if (en_q) begin
      count_d = dir_q ? (count_q + C_ONE) : (count_q - C_ONE);
    end
    // Counting above uses the current config; new config lands next edge.
    en_d  = config_we ? en_in  : en_q;
    dir_d = config_we ? dir_in : dir_q;
    ire_d = config_we ? ire_in : ire_q;
    irq_d = wrap && ire_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      en_q    <= 1'b0;
      dir_q   <= 1'b1;
      ire_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      ire_q   <= ire_d;
      irq_q   <= irq_d;
    end
  end

  assign count_out = count_q;
  assign en_out    = en_q;
  assign dir_out   = dir_q;
  assign ire_out   = ire_q;
  assign count_irq = irq_q;
  assign lt_1k_out = (count_q < C_LT);

  peripheral_sync_fifo #(
    .DEPTH       (FIFO_DEPTH),
    .DATA_WIDTH  (FIFO_DATA_WIDTH),
    .COUNT_WIDTH (FIFO_COUNT_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .we         (fifo_we),
    .data_in    (fifo_data_in),
    .re         (fifo_re),
    .data_out   (fifo_data_out),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .word_count (fifo_word_count)
  );

endmodule : peripheral_native_registers
`default_nettype wire
